// File: rtl/wc_pkg.sv
// -----------------------------------------------------------------------------
// wc_pkg
//   Shared definitions for the Hamming-weight classifier:
//   - clog2()    : elaboration-time ceil(log2(value)), used for derived widths.
//   - wc_mode_e  : named mode encodings for the 7-bit configuration, where
//                  popcount(count) selects the class:
//                    MODE_ZERO {0}, MODE_POW2 {1,2,4}, MODE_W2 {3,5,6}, MODE_W3 {7}.
//   - sat_inc()  : saturating increment on a 64-bit carrier. Callers
//                  zero-extend their counter and cast the result back.
// -----------------------------------------------------------------------------
package wc_pkg;

  // Returns ceil(log2(value)). Returns 0 for value <= 1.
  // The loop bound is fixed, so this also serves as a constant function.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Mode encodings for WIDTH=7. Other widths use raw mode values.
  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_POW2 = 2'd1,
    MODE_W2   = 2'd2,
    MODE_W3   = 2'd3
  } wc_mode_e;

  // Counters up to 64 bits wide can share this helper.
  localparam int SAT_CARRIER_W = 64;

  // Adds one unless the value has already reached max_value.
  function automatic logic [SAT_CARRIER_W-1:0] sat_inc(
    input logic [SAT_CARRIER_W-1:0] value,
    input logic [SAT_CARRIER_W-1:0] max_value
  );
    return (value >= max_value) ? max_value : value + 64'd1;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// -----------------------------------------------------------------------------
// popcount_tree
//   Purely combinational population count, built as a recursive adder tree.
//   The input splits into a low half and a high half. Each half is counted by
//   a smaller instance of this module, and the two counts are added. A 1-bit
//   input is its own count. The tree depth is therefore ceil(log2(W)).
//
// Parameters
//   W      : input width, >= 1
//   OUT_W  : derived, clog2(W+1); just wide enough to hold W
//
// Ports
//   i_data   in  [W-1:0]      word whose set bits are counted
//   o_count  out [OUT_W-1:0]  number of ones in i_data
// -----------------------------------------------------------------------------
module popcount_tree
  import wc_pkg::*;
#(
  parameter  int W     = 7,
  localparam int OUT_W = clog2(W + 1)
) (
  input  logic [W-1:0]     i_data,
  output logic [OUT_W-1:0] o_count
);

  generate
    if (W == 1) begin : g_leaf
      // A single bit is its own count (OUT_W == 1 here).
      assign o_count = i_data;
    end else begin : g_split
      localparam int LO_W  = W / 2;
      localparam int HI_W  = W - LO_W;
      localparam int LO_CW = clog2(LO_W + 1);
      localparam int HI_CW = clog2(HI_W + 1);

      logic [LO_CW-1:0] w_lo_count;
      logic [HI_CW-1:0] w_hi_count;

      popcount_tree #(.W(LO_W)) u_lo (
        .i_data  (i_data[LO_W-1:0]),
        .o_count (w_lo_count)
      );

      popcount_tree #(.W(HI_W)) u_hi (
        .i_data  (i_data[W-1:LO_W]),
        .o_count (w_hi_count)
      );

      // Both partial counts are zero-extended to OUT_W before the add.
      // The sum is at most W, so OUT_W bits cannot overflow.
      assign o_count = OUT_W'(w_lo_count) + OUT_W'(w_hi_count);
    end
  endgenerate

endmodule

// File: rtl/weight_class_pipe.sv
// -----------------------------------------------------------------------------
// weight_class_pipe
//   Two-stage pipelined Hamming-weight classifier with valid/ready flow
//   control and delivery statistics.
//
//   Stage 1 registers popcount(in_data) together with in_mode.
//   Stage 2 registers that count and a match flag:
//       match = (popcount(count) == mode)
//   Both stages advance together whenever the output register is empty or
//   being drained. This makes the pipe a strict FIFO that never drops or
//   duplicates a word.
//
// Parameters
//   WIDTH   : input word width, >= 1
//   STAT_W  : statistics counter width, >= 2 (saturating counters)
//   CNT_W   : derived, clog2(WIDTH+1)  - popcount width
//   MODE_W  : derived, clog2(CNT_W+1)  - mode select width
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous assert, active-low reset
//   in_valid    in   in_data / in_mode valid
//   in_ready    out  word accepted this cycle (independent of in_valid)
//   in_data     in   [WIDTH-1:0]   word to classify
//   in_mode     in   [MODE_W-1:0]  class select, sampled with in_data
//   out_valid   out  result valid
//   out_ready   in   sink accepts the result
//   out_count   out  [CNT_W-1:0]   number of ones in the word
//   out_match   out  popcount(out_count) == mode
//   stat_clr    in   synchronous clear of both statistics counters
//   stat_total  out  [STAT_W-1:0]  results delivered (saturating)
//   stat_match  out  [STAT_W-1:0]  delivered results with out_match=1 (saturating)
// -----------------------------------------------------------------------------
module weight_class_pipe
  import wc_pkg::*;
#(
  parameter  int WIDTH  = 7,
  parameter  int STAT_W = 16,
  localparam int CNT_W  = clog2(WIDTH + 1),
  localparam int MODE_W = clog2(CNT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0] in_mode,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_match,

  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_total,
  output logic [STAT_W-1:0] stat_match
);

  // All-ones value of a STAT_W counter, on the 64-bit carrier used by sat_inc.
  // For STAT_W == 64 the shift yields 0, and 0 - 1 is still all ones.
  localparam logic [SAT_CARRIER_W-1:0] STAT_MAX =
    (64'd1 << STAT_W) - 64'd1;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic              r_s1_valid;
  logic [CNT_W-1:0]  r_s1_count;
  logic [MODE_W-1:0] r_s1_mode;

  logic              r_s2_valid;
  logic [CNT_W-1:0]  r_s2_count;
  logic              r_s2_match;

  logic [STAT_W-1:0] r_stat_total;
  logic [STAT_W-1:0] r_stat_match;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  w_in_count;    // popcount of the incoming word
  logic [MODE_W-1:0] w_cnt_weight;  // popcount of the stage-1 count
  logic              w_s1_match;
  logic              w_advance;
  logic              w_out_hs;
  logic [STAT_W-1:0] w_total_inc;
  logic [STAT_W-1:0] w_match_inc;

  popcount_tree #(.W(WIDTH)) u_pc_data (
    .i_data  (in_data),
    .o_count (w_in_count)
  );

  // The weight of the count fits in MODE_W bits, at most CNT_W.
  // A mode value above CNT_W can therefore never compare equal.
  popcount_tree #(.W(CNT_W)) u_pc_count (
    .i_data  (r_s1_count),
    .o_count (w_cnt_weight)
  );

  assign w_s1_match = (w_cnt_weight == r_s1_mode);

  // The pipe moves as a whole when the output slot is empty or being drained.
  // in_ready must not depend on in_valid, so it is exactly this term.
  assign w_advance = !r_s2_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_out_hs  = r_s2_valid && out_ready;

  // Saturating increments, computed on the wide carrier and narrowed back.
  assign w_total_inc = STAT_W'(sat_inc(64'(r_stat_total), STAT_MAX));
  assign w_match_inc = STAT_W'(sat_inc(64'(r_stat_match), STAT_MAX));

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with non-blocking assignments.
  // Stage 2 then reads the pre-edge stage-1 value, and the two stages shift
  // in one edge instead of stage 1 falling straight through into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data fields are reset along with the valid bits because
      // out_count and out_match are visible outputs with defined reset values.
      // These are plain flops, not a memory array, so resetting them is cheap.
      r_s1_valid <= 1'b0;
      r_s1_count <= '0;
      r_s1_mode  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_count <= '0;
      r_s2_match <= 1'b0;
    end else if (w_advance) begin
      // Stage 1 takes whatever is on the input. A cycle with in_valid low
      // simply inserts a bubble.
      r_s1_valid <= in_valid;
      r_s1_count <= w_in_count;
      r_s1_mode  <= in_mode;
      r_s2_valid <= r_s1_valid;
      r_s2_count <= r_s1_count;
      r_s2_match <= w_s1_match;
    end
    // With no advance, both stages hold. The output therefore stays stable
    // while the sink is stalling.
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  // A clear has priority over a handshake in the same cycle. The delivered
  // result is then not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_total <= '0;
      r_stat_match <= '0;
    end else if (stat_clr) begin
      r_stat_total <= '0;
      r_stat_match <= '0;
    end else if (w_out_hs) begin
      r_stat_total <= w_total_inc;
      if (r_s2_match) r_stat_match <= w_match_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid  = r_s2_valid;
  assign out_count  = r_s2_count;
  assign out_match  = r_s2_match;
  assign stat_total = r_stat_total;
  assign stat_match = r_stat_match;

endmodule

// File: tb/tb_weight_class_pipe.sv
// -----------------------------------------------------------------------------
// tb_weight_class_pipe
//   Directed bench for weight_class_pipe at WIDTH=7.
//   Two instances share all inputs:
//     u_dut     STAT_W=16
//     u_dut_s4  STAT_W=4, so saturation at 15 is reachable.
//   Inputs are driven 1 time unit after the rising edge. Outputs are read
//   between edges, and delivered results are collected on the falling edge.
// -----------------------------------------------------------------------------
module tb_weight_class_pipe;
  import wc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_count;
  logic        out_match;
  logic        stat_clr;
  logic [15:0] stat_total;
  logic [15:0] stat_match;

  logic        s4_in_ready;
  logic        s4_out_valid;
  logic [2:0]  s4_out_count;
  logic        s4_out_match;
  logic [3:0]  s4_stat_total;
  logic [3:0]  s4_stat_match;

  int tests_run    = 0;
  int tests_failed = 0;

  // Delivered results, packed as {count, match}.
  logic [3:0] got_q[$];

  // Hand-computed results for words 1..10, with mode = word % 4.
  logic [2:0] stall_exp_cnt [10] = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd1, 3'd2, 3'd2};
  logic       stall_exp_m   [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  weight_class_pipe #(.WIDTH(7), .STAT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_match  (out_match),
    .stat_clr   (stat_clr),
    .stat_total (stat_total),
    .stat_match (stat_match)
  );

  weight_class_pipe #(.WIDTH(7), .STAT_W(4)) u_dut_s4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (s4_in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (s4_out_valid),
    .out_ready  (out_ready),
    .out_count  (s4_out_count),
    .out_match  (s4_out_match),
    .stat_clr   (stat_clr),
    .stat_total (s4_stat_total),
    .stat_match (s4_stat_match)
  );

  // Result collector: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_count, out_match});
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 7'h7f;
    in_mode   = MODE_W3;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || s4_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got=%b/%b exp=0/0", out_valid, s4_out_valid);
    end
    tests_run++;
    if (out_count !== 3'd0 || out_match !== 1'b0 || s4_out_count !== 3'd0 || s4_out_match !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_data got=%0d,%b exp=0,0", out_count, out_match);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || s4_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got=%b/%b exp=1/1", in_ready, s4_in_ready);
    end
    tests_run++;
    if (stat_total !== 16'd0 || stat_match !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_total, stat_match);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single(input logic [6:0] data, input logic [1:0] mode,
                             input logic [2:0] exp_cnt, input logic exp_m);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = data;
    in_mode   = mode;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_in_ready data=%b got=%b exp=1", data, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early_valid data=%b got=%b exp=0", data, out_valid);
    end
    next_cycle();
    tests_run++;
    if (out_valid !== 1'b1 || out_count !== exp_cnt || out_match !== exp_m) begin
      tests_failed++;
      $display("FAIL single_result data=%b mode=%0d got v=%b cnt=%0d m=%b exp v=1 cnt=%0d m=%b",
               data, mode, out_valid, out_count, out_match, exp_cnt, exp_m);
    end
    next_cycle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drained data=%b got=%b exp=0", data, out_valid);
    end
  endtask

  task automatic test_single_stats();
    // The four single words delivered 4 results, three of them matching.
    tests_run++;
    if (stat_total !== 16'd4 || stat_match !== 16'd3) begin
      tests_failed++;
      $display("FAIL single_stats got=%0d/%0d exp=4/3", stat_total, stat_match);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int seen;
    seen = 0;
    pulse_clr();
    out_ready = 1'b1;
    in_data   = 7'b0001011;
    in_mode   = MODE_W2;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      next_cycle();
      // Word i is accepted at edge i and is visible after edge i+1.
      if (out_valid !== ((i >= 1 && i <= 8) ? 1'b1 : 1'b0)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL b2b_valid cycle=%0d got=%b", i, out_valid);
      end
      if (out_valid === 1'b1) begin
        seen++;
        tests_run++;
        if (out_count !== 3'd3 || out_match !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_result cycle=%0d got cnt=%0d m=%b exp cnt=3 m=1", i, out_count, out_match);
        end
      end
    end
    tests_run++;
    if (seen != 8) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d exp=8", seen);
    end
    tests_run++;
    if (stat_total !== 16'd8 || stat_match !== 16'd8) begin
      tests_failed++;
      $display("FAIL b2b_stats got=%0d/%0d exp=8/8", stat_total, stat_match);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall();
    int         idx;
    int         c;
    int         ready_low;
    logic       prev_stall;
    logic [2:0] prev_cnt;
    logic       prev_m;
    idx        = 0;
    c          = 0;
    ready_low  = 0;
    prev_stall = 1'b0;
    prev_cnt   = '0;
    prev_m     = 1'b0;
    got_q.delete();
    while (c < 60 && got_q.size() < 10) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (idx < 10);
      in_data   = 7'(idx + 1);
      in_mode   = 2'((idx + 1) % 4);
      #1;
      if (in_ready !== (!out_valid || out_ready)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL stall_in_ready cycle=%0d got=%b", c, in_ready);
      end
      if (in_ready === 1'b0) ready_low++;
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_count !== prev_cnt || out_match !== prev_m) begin
          tests_failed++;
          $display("FAIL stall_hold cycle=%0d got v=%b cnt=%0d m=%b exp v=1 cnt=%0d m=%b",
                   c, out_valid, out_count, out_match, prev_cnt, prev_m);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_cnt   = out_count;
      prev_m     = out_match;
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (ready_low == 0) begin
      tests_failed++;
      $display("FAIL stall_backpressure got=0 in_ready-low cycles exp>0");
    end
    tests_run++;
    if (got_q.size() != 10) begin
      tests_failed++;
      $display("FAIL stall_count got=%0d exp=10", got_q.size());
    end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== {stall_exp_cnt[i], stall_exp_m[i]}) begin
        tests_failed++;
        $display("FAIL stall_order idx=%0d got cnt=%0d m=%b exp cnt=%0d m=%b",
                 i, got_q[i][3:1], got_q[i][0], stall_exp_cnt[i], stall_exp_m[i]);
      end
    end
    repeat (3) next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    pulse_clr();
    out_ready = 1'b1;
    in_data   = 7'b0000001;
    in_mode   = MODE_POW2;
    in_valid  = 1'b1;
    repeat (20) next_cycle();
    in_valid = 1'b0;
    repeat (3) next_cycle();
    tests_run++;
    if (s4_stat_total !== 4'd15 || s4_stat_match !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_s4 got=%0d/%0d exp=15/15", s4_stat_total, s4_stat_match);
    end
    tests_run++;
    if (stat_total !== 16'd20 || stat_match !== 16'd20) begin
      tests_failed++;
      $display("FAIL sat_s16 got=%0d/%0d exp=20/20", stat_total, stat_match);
    end
    // Clear in the same cycle as a handshake: the clear wins.
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    stat_clr = 1'b1;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_hs_setup got=%b exp=1", out_valid);
    end
    next_cycle();
    stat_clr = 1'b0;
    tests_run++;
    if (stat_total !== 16'd0 || stat_match !== 16'd0 || s4_stat_total !== 4'd0 || s4_stat_match !== 4'd0) begin
      tests_failed++;
      $display("FAIL clr_with_hs got=%0d/%0d,%0d/%0d exp=0/0,0/0",
               stat_total, stat_match, s4_stat_total, s4_stat_match);
    end
    // A non-matching word counts toward total only (count 1, weight 1 != mode 0).
    in_mode  = MODE_ZERO;
    in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    repeat (3) next_cycle();
    tests_run++;
    if (stat_total !== 16'd1 || stat_match !== 16'd0 || s4_stat_total !== 4'd1 || s4_stat_match !== 4'd0) begin
      tests_failed++;
      $display("FAIL nomatch_stats got=%0d/%0d,%0d/%0d exp=1/0,1/0",
               stat_total, stat_match, s4_stat_total, s4_stat_match);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    int stale;
    stale     = 0;
    out_ready = 1'b0;
    in_data   = 7'b1111111;
    in_mode   = MODE_W3;
    in_valid  = 1'b1;
    repeat (3) next_cycle();
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_full got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
    end
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || s4_out_valid !== 1'b0 || out_count !== 3'd0 || out_match !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async got v=%b cnt=%0d m=%b exp v=0 cnt=0 m=0", out_valid, out_count, out_match);
    end
    tests_run++;
    if (stat_total !== 16'd0 || s4_stat_total !== 4'd0) begin
      tests_failed++;
      $display("FAIL midrst_stats got=%0d/%0d exp=0/0", stat_total, s4_stat_total);
    end
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    repeat (5) begin
      next_cycle();
      if (out_valid !== 1'b0) stale++;
    end
    tests_run++;
    if (stale != 0 || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midrst_stale got=%0d valid cycles,%0d results exp=0,0", stale, got_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single(7'b0000000, MODE_ZERO, 3'd0, 1'b1);
    test_single(7'b0010110, MODE_POW2, 3'd3, 1'b0);
    test_single(7'b0010110, MODE_W2,   3'd3, 1'b1);
    test_single(7'b1111111, MODE_W3,   3'd7, 1'b1);
    test_single_stats();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
